// File: rtl/codec_config_sequencer.sv
// codec_config_sequencer: walks the WM8731 power-up register table over I2C with NACK/timeout retries.
module codec_config_sequencer #(
  parameter int         POWERUP_CYCLES = 1000,
  parameter int         GAP_CYCLES     = 20,
  parameter int         TIMEOUT_CYCLES = 500,
  parameter int         MAX_RETRY      = 3,
  parameter logic [6:0] DEV_ADDR       = 7'h1A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reconfig,
  input  logic        i2c_busy,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        i2c_start,
  output logic [6:0]  i2c_dev,
  output logic [15:0] i2c_word,
  output logic [3:0]  cur_index,
  output logic [1:0]  retry_count,
  output logic        config_busy,
  output logic        config_done,
  output logic        config_err
);
  localparam int CNT_MAX = POWERUP_CYCLES > TIMEOUT_CYCLES ?
    (POWERUP_CYCLES > GAP_CYCLES ? POWERUP_CYCLES : GAP_CYCLES) :
    (TIMEOUT_CYCLES > GAP_CYCLES ? TIMEOUT_CYCLES : GAP_CYCLES);
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [2:0] POWERUP = 3'd0, ISSUE = 3'd1, WAIT = 3'd2, GAP = 3'd3, DONE = 3'd4, FAIL = 3'd5;
  localparam logic [3:0] LAST = 4'd10;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [15:0]   entry;

  assign i2c_dev     = DEV_ADDR;
  assign config_busy = state != DONE && state != FAIL;

  // {reg_addr[6:0], reg_data[8:0]}; entry 0 soft-resets the codec, entry 10 activates it
  always_comb begin
    entry = '0;
    case (cur_index)
      4'd0:  entry = {7'h0F, 9'h000};
      4'd1:  entry = {7'h00, 9'h017};
      4'd2:  entry = {7'h01, 9'h017};
      4'd3:  entry = {7'h02, 9'h079};
      4'd4:  entry = {7'h03, 9'h079};
      4'd5:  entry = {7'h04, 9'h015};
      4'd6:  entry = {7'h05, 9'h000};
      4'd7:  entry = {7'h06, 9'h000};
      4'd8:  entry = {7'h07, 9'h042};
      4'd9:  entry = {7'h08, 9'h000};
      4'd10: entry = {7'h09, 9'h001};
      default: entry = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= POWERUP;
      cnt         <= '0;
      i2c_start   <= 1'b0;
      i2c_word    <= '0;
      cur_index   <= '0;
      retry_count <= '0;
      config_done <= 1'b0;
      config_err  <= 1'b0;
    end else begin
      i2c_start <= 1'b0;
      case (state)
        POWERUP: if (cnt == CW'(POWERUP_CYCLES - 1)) begin
          cnt   <= '0;
          state <= ISSUE;
        end else cnt <= cnt + 1'b1;
        ISSUE: if (!i2c_busy) begin
          i2c_word  <= entry;
          i2c_start <= 1'b1;
          cnt       <= '0;
          state     <= WAIT;
        end
        // a done arriving on the timeout cycle still counts as the engine's answer
        WAIT: if (i2c_done && !i2c_nack) begin
          cnt         <= '0;
          retry_count <= '0;
          if (cur_index == LAST) begin
            state       <= DONE;
            config_done <= 1'b1;
          end else begin
            cur_index <= cur_index + 1'b1;
            state     <= GAP;
          end
        end else if (i2c_done || cnt == CW'(TIMEOUT_CYCLES)) begin
          cnt <= '0;
          if (retry_count == 2'(MAX_RETRY)) begin
            state      <= FAIL;
            config_err <= 1'b1;
          end else begin
            retry_count <= retry_count + 1'b1;
            state       <= GAP;
          end
        end else cnt <= cnt + 1'b1;
        GAP: if (cnt == CW'(GAP_CYCLES - 1)) begin
          cnt   <= '0;
          state <= ISSUE;
        end else cnt <= cnt + 1'b1;
        DONE, FAIL: if (reconfig) begin
          cnt         <= '0;
          cur_index   <= '0;
          retry_count <= '0;
          config_done <= 1'b0;
          config_err  <= 1'b0;
          state       <= GAP;
        end
        default: state <= POWERUP;
      endcase
    end
  end
endmodule

// File: tb/tb_codec_config_sequencer.sv
// tb_codec_config_sequencer: directed checks of the codec table walk against a scripted I2C engine.
module tb_codec_config_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reconfig = 1'b0;
  logic        i2c_busy = 1'b0;
  logic        i2c_done;
  logic        i2c_nack;
  logic        i2c_start;
  logic [6:0]  i2c_dev;
  logic [15:0] i2c_word;
  logic [3:0]  cur_index;
  logic [1:0]  retry_count;
  logic        config_busy;
  logic        config_done;
  logic        config_err;

  codec_config_sequencer dut (
    .clk(clk), .reset(reset), .reconfig(reconfig), .i2c_busy(i2c_busy),
    .i2c_done(i2c_done), .i2c_nack(i2c_nack), .i2c_start(i2c_start), .i2c_dev(i2c_dev),
    .i2c_word(i2c_word), .cur_index(cur_index), .retry_count(retry_count),
    .config_busy(config_busy), .config_done(config_done), .config_err(config_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  // engine script, written only by the main process
  int lat = 40, nack_idx = -1, nack_cnt = 0, silent_idx = -1;
  int spur_req = 0;
  // engine log, written only by the engine process
  int spur_ack = 0;
  int n_starts = 0;
  int start_cyc [64];
  logic [15:0] start_word [64];
  int start_idx [64];
  int attempts [16];
  logic [15:0] exp_w [11] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0815,
                              16'h0A00, 16'h0C00, 16'h0E42, 16'h1000, 16'h1201};

  initial forever begin
    @(posedge clk);
    cyc = reset ? 0 : cyc + 1;
  end

  initial begin
    bit pend;
    bit due_nack;
    int due;
    pend = 0; due = 0; due_nack = 0;
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
    forever begin
      @(negedge clk);
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      if (reset) begin
        pend = 0;
        n_starts = 0;
        spur_ack = spur_req;
        for (int i = 0; i < 16; i++) attempts[i] = 0;
      end else begin
        if (spur_req != spur_ack) begin
          i2c_done = 1'b1;
          spur_ack++;
        end
        if (pend && cyc == due) begin
          i2c_done = 1'b1;
          i2c_nack = due_nack;
          pend = 0;
        end
        if (i2c_start && n_starts < 64) begin
          start_cyc[n_starts] = cyc;
          start_word[n_starts] = i2c_word;
          start_idx[n_starts] = int'(cur_index);
          n_starts++;
          attempts[cur_index]++;
          if (int'(cur_index) != silent_idx) begin
            pend = 1;
            due = cyc + lat;
            due_nack = int'(cur_index) == nack_idx && attempts[cur_index] <= nack_cnt;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic setup(input int l, input int ni, input int nc, input int si);
    lat = l; nack_idx = ni; nack_cnt = nc; silent_idx = si;
  endtask

  task automatic wait_end(input string tag, input int maxc, output int at, output int max_retry);
    at = -1;
    max_retry = 0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (int'(retry_count) > max_retry) max_retry = int'(retry_count);
      if (config_done || config_err) begin
        at = cyc;
        break;
      end
    end
    check({tag, "_end_tmo"}, at >= 0, 1);
  endtask

  task automatic wait_starts(input string tag, input int k, input int maxc);
    for (int i = 0; i < maxc && n_starts < k; i++) tick();
    check({tag, "_start_tmo"}, n_starts >= k, 1);
  endtask

  task automatic wait_cyc(input int c);
    for (int i = 0; i < 5000 && cyc < c; i++) tick();
  endtask

  initial begin
    int at, mr, c0;
    // 1: ideal engine, with reset values checked while reset is held
    setup(40, -1, 0, -1);
    reset = 1'b1;
    tick();
    check("rst_start", i2c_start, 0);
    check("rst_word", i2c_word, 0);
    check("rst_idx", cur_index, 0);
    check("rst_retry", retry_count, 0);
    check("rst_busy", config_busy, 1);
    check("rst_done", config_done, 0);
    check("rst_err", config_err, 0);
    check("dev", i2c_dev, 7'h1A);
    do_reset();
    wait_end("s1", 3000, at, mr);
    check("s1_nstarts", n_starts, 11);
    check("s1_first", start_cyc[0], 1001);
    for (int i = 0; i < 11; i++) check($sformatf("s1_word%0d", i), start_word[i], exp_w[i]);
    check("s1_gap", start_cyc[1] - start_cyc[0], 62);
    check("s1_done_lat", at, start_cyc[10] + 41);
    check("s1_done", config_done, 1);
    check("s1_err", config_err, 0);
    check("s1_busy", config_busy, 0);

    // 2: two NACKs on entry 8, then ack
    setup(40, 8, 2, -1);
    do_reset();
    wait_end("s2", 3000, at, mr);
    check("s2_att8", attempts[8], 3);
    check("s2_nstarts", n_starts, 13);
    check("s2_gap_a", start_cyc[9] - start_cyc[8], 62);
    check("s2_gap_b", start_cyc[10] - start_cyc[9], 62);
    check("s2_retry_word", start_word[10], 16'h0E42);
    check("s2_maxretry", mr, 2);
    check("s2_retry_end", retry_count, 0);
    check("s2_done", config_done, 1);

    // 3: entry 3 always NACKs
    setup(40, 3, 99, -1);
    do_reset();
    wait_end("s3", 3000, at, mr);
    check("s3_att3", attempts[3], 4);
    check("s3_err", config_err, 1);
    check("s3_done", config_done, 0);
    check("s3_idx", cur_index, 3);
    check("s3_busy", config_busy, 0);
    check("s3_retry", retry_count, 3);
    repeat (200) tick();
    check("s3_nstarts", n_starts, 7);

    // 4a: engine silent on entry 0 -> timeouts
    setup(40, -1, 0, 0);
    do_reset();
    wait_end("s4a", 5000, at, mr);
    check("s4a_nstarts", n_starts, 4);
    check("s4a_period", start_cyc[1] - start_cyc[0], 522);
    check("s4a_retry_idx", start_idx[3], 0);
    check("s4a_err", config_err, 1);
    check("s4a_fail_lat", at, start_cyc[3] + 501);
    // 4b: done lands exactly on the timeout cycle -> success
    setup(500, -1, 0, -1);
    do_reset();
    wait_starts("s4b", 2, 3000);
    check("s4b_period", start_cyc[1] - start_cyc[0], 522);
    check("s4b_idx", start_idx[1], 1);
    check("s4b_retry", retry_count, 0);

    // 5: async reset in WAIT at entry 5, ignored reconfig, reconfig in DONE
    setup(40, -1, 0, -1);
    do_reset();
    wait_starts("s5a", 6, 2000);
    repeat (10) tick();
    check("s5_pre_idx", cur_index, 5);
    reset = 1'b1;
    #1;
    check("s5_arst_idx", cur_index, 0);
    check("s5_arst_word", i2c_word, 0);
    check("s5_arst_busy", config_busy, 1);
    do_reset();
    wait_starts("s5b", 3, 2000);
    reconfig = 1'b1;
    tick();
    reconfig = 1'b0;
    wait_end("s5", 3000, at, mr);
    check("s5_restart_word", start_word[0], 16'h1E00);
    check("s5_first", start_cyc[0], 1001);
    check("s5_nstarts", n_starts, 11);
    check("s5_done", config_done, 1);
    c0 = cyc;
    reconfig = 1'b1;
    tick();
    reconfig = 1'b0;
    check("s5_done_clr", config_done, 0);
    wait_starts("s5c", 12, 100);
    check("s5_reconf_lat", start_cyc[11] - c0, 22);
    check("s5_reconf_idx", start_idx[11], 0);

    // 6: busy held in ISSUE, spurious dones in GAP
    setup(40, -1, 0, -1);
    do_reset();
    wait_cyc(995);
    i2c_busy = 1'b1;
    wait_cyc(1095);
    check("s6_held", n_starts, 0);
    i2c_busy = 1'b0;
    wait_starts("s6a", 1, 20);
    check("s6_start", start_cyc[0], 1096);
    wait_cyc(1140);
    spur_req++;
    repeat (3) tick();
    spur_req++;
    repeat (3) tick();
    check("s6_spur_idx", cur_index, 1);
    check("s6_spur_retry", retry_count, 0);
    wait_starts("s6b", 2, 100);
    check("s6_next_idx", start_idx[1], 1);
    check("s6_next_cyc", start_cyc[1], 1158);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
